// File: rtl/iiitb_3bit_rr_arbiter.sv
// iiitb_3bit_rr_arbiter: three-way round-robin arbiter with registered one-hot
// grants and a one-hot rotating priority pointer. A grant is held while its
// owner keeps requesting, and on release it passes straight to the next winner
// without an idle cycle.
// Optional feature macro: IIITB_RR_HOLD_LIMIT_EN. When it is defined, a holder
// that has owned the grant for MAX_HOLD cycles is preempted if anyone else is
// waiting.
module iiitb_3bit_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] Req,
  output logic [2:0] Grant,
  output logic       Grant_valid,
  output logic [1:0] Grant_id,
  output logic [2:0] Ptr_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state, state_n;
  logic [2:0] grant_n;
  logic [2:0] ptr_n;
  logic [2:0] others_req;
  logic [2:0] win;
  logic       holder_req;

  // Reject an illegal hold limit at elaboration time.
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("MAX_HOLD must be in the range 1..15");
  end

`ifdef IIITB_RR_HOLD_LIMIT_EN
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  logic [3:0] hold_cnt, hold_cnt_n;
`endif

  // Pick the first requester at or after the pointer bit, scanning 0->1->2->0.
  // The request vector is rotated so the pointer position lands on bit 0, the
  // lowest set bit is isolated, and the result is rotated back.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [2:0] req);
    logic [2:0] rot_req;
    logic [2:0] rot_win;
    logic [2:0] result;
    case (ptr)
      3'b010:  rot_req = {req[0], req[2], req[1]};
      3'b100:  rot_req = {req[1], req[0], req[2]};
      default: rot_req = req;
    endcase
    rot_win = rot_req & (~rot_req + 3'd1);
    case (ptr)
      3'b010:  result = {rot_win[1], rot_win[0], rot_win[2]};
      3'b100:  result = {rot_win[0], rot_win[2], rot_win[1]};
      default: result = rot_win;
    endcase
    return result;
  endfunction

  // Next-state, next-grant and pointer decisions for both states.
  always_comb begin
    state_n    = state;
    grant_n    = Grant;
    ptr_n      = Ptr_out;
    others_req = Req & ~Grant;
    holder_req = |(Req & Grant);
    win        = 3'b000;
`ifdef IIITB_RR_HOLD_LIMIT_EN
    hold_cnt_n = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (|Req) begin
          win     = rr_pick(Ptr_out, Req);
          grant_n = win;
          ptr_n   = {win[1:0], win[2]};
          state_n = OWNED;
`ifdef IIITB_RR_HOLD_LIMIT_EN
          hold_cnt_n = 4'd1;
`endif
        end
      end
      OWNED: begin
        if (!holder_req) begin
          // Owner released: hand over in the same edge if anyone else waits.
          win = rr_pick(Ptr_out, others_req);
          if (|win) begin
            grant_n = win;
            ptr_n   = {win[1:0], win[2]};
`ifdef IIITB_RR_HOLD_LIMIT_EN
            hold_cnt_n = 4'd1;
`endif
          end else begin
            grant_n = 3'b000;
            state_n = IDLE;
`ifdef IIITB_RR_HOLD_LIMIT_EN
            hold_cnt_n = 4'd0;
`endif
          end
        end
`ifdef IIITB_RR_HOLD_LIMIT_EN
        else if (hold_cnt == HOLD_MAX && |others_req) begin
          // Hold limit reached with others waiting: force a hand-over.
          win        = rr_pick(Ptr_out, others_req);
          grant_n    = win;
          ptr_n      = {win[1:0], win[2]};
          hold_cnt_n = 4'd1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_n = hold_cnt + 4'd1;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        grant_n = 3'b000;
      end
    endcase
  end

  // Register state and all outputs so nothing combinational reaches the ports.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      Grant       <= 3'b000;
      Grant_valid <= 1'b0;
      Grant_id    <= 2'b00;
      Ptr_out     <= 3'b001;
    end else begin
      state       <= state_n;
      Grant       <= grant_n;
      Grant_valid <= |grant_n;
      Grant_id    <= {grant_n[2], grant_n[1]};
      Ptr_out     <= ptr_n;
    end
  end

`ifdef IIITB_RR_HOLD_LIMIT_EN
  // Hold counter: cycles the current owner has held its grant.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold_cnt <= 4'd0;
    end else begin
      hold_cnt <= hold_cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_iiitb_3bit_rr_arbiter.sv
// tb_iiitb_3bit_rr_arbiter: self-checking bench for the round-robin arbiter.
// A requester-index reference model predicts every output each cycle; directed
// sequences add hand-derived expectations on top.
module tb_iiitb_3bit_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       Clock;
  logic       Reset;
  logic [2:0] Req;
  logic [2:0] Grant;
  logic       Grant_valid;
  logic [1:0] Grant_id;
  logic [2:0] Ptr_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner index (-1 = none), priority index, hold age.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_cnt    = 0;

  iiitb_3bit_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .Grant      (Grant),
    .Grant_valid(Grant_valid),
    .Grant_id   (Grant_id),
    .Ptr_out    (Ptr_out)
  );

  // Free-running clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
    end
  endtask

  function automatic int pick(input int ptr, input logic [2:0] req, input int excl);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (ptr + k) % 3;
      if (req[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic void modelGrant(input int w);
    m_holder = w;
    m_ptr    = (w + 1) % 3;
    m_cnt    = 1;
  endfunction

  function automatic void modelStep(input logic [2:0] req, input logic rst);
    int w;
    if (rst) begin
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
    end else if (m_holder < 0) begin
      w = pick(m_ptr, req, -1);
      if (w >= 0) modelGrant(w);
    end else if (!req[m_holder]) begin
      w = pick(m_ptr, req, m_holder);
      if (w >= 0) modelGrant(w);
      else begin
        m_holder = -1;
        m_cnt    = 0;
      end
    end else begin
`ifdef IIITB_RR_HOLD_LIMIT_EN
      w = pick(m_ptr, req, m_holder);
      if (m_cnt == MAX_HOLD && w >= 0) modelGrant(w);
      else if (m_cnt < MAX_HOLD) m_cnt++;
`endif
    end
  endfunction

  // Drive one cycle of inputs, advance the model, and compare all outputs.
  task automatic applyStimulus(input logic [2:0] req, input logic rst);
    logic [2:0] expGrant;
    @(negedge Clock);
    Req   = req;
    Reset = rst;
    @(posedge Clock);
    modelStep(req, rst);
    #1;
    expGrant = (m_holder < 0) ? 3'b000 : 3'(1 << m_holder);
    checkOutput("grant",       8'(Grant),       8'(expGrant));
    checkOutput("grant_valid", 8'(Grant_valid), 8'(m_holder >= 0));
    checkOutput("grant_id",    8'(Grant_id),    8'((m_holder < 0) ? 0 : m_holder));
    checkOutput("ptr_out",     8'(Ptr_out),     8'(1 << m_ptr));
  endtask

  logic [2:0] rotReq   [8] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b111};
  logic [2:0] rotGrant [8] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
  logic [2:0] rotPtr   [8] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b010};

  initial begin
    Req   = 3'b000;
    Reset = 1'b1;

    // Reset, then idle with no requests.
    applyStimulus(3'b111, 1'b1);
    applyStimulus(3'b000, 1'b1);
    checkOutput("reset_ptr", 8'(Ptr_out), 8'h01);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b000, 1'b0);
      checkOutput("idle_grant", 8'(Grant), 8'h00);
    end

    // Rotation with each holder dropping after two granted cycles.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(rotReq[i], 1'b0);
      checkOutput("rot_grant", 8'(Grant), 8'(rotGrant[i]));
      checkOutput("rot_ptr", 8'(Ptr_out), 8'(rotPtr[i]));
    end

    // Lone high requester after reset, then hand-over to requester 0.
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b100, 1'b0);
    checkOutput("lone2_grant", 8'(Grant), 8'h04);
    checkOutput("lone2_ptr", 8'(Ptr_out), 8'h01);
    applyStimulus(3'b101, 1'b0);
    applyStimulus(3'b001, 1'b0);
    checkOutput("handover0", 8'(Grant), 8'h01);

    // Reset in the middle of a grant with all requests pending.
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b010, 1'b0);
    checkOutput("mid_grant", 8'(Grant), 8'h02);
    applyStimulus(3'b111, 1'b1);
    checkOutput("midrst_grant", 8'(Grant), 8'h00);
    checkOutput("midrst_ptr", 8'(Ptr_out), 8'h01);
    applyStimulus(3'b111, 1'b0);
    checkOutput("postrst_grant", 8'(Grant), 8'h01);

    // Two constant requesters: hold limit alternation or indefinite hold.
    applyStimulus(3'b000, 1'b1);
`ifdef IIITB_RR_HOLD_LIMIT_EN
    for (int k = 0; k < 16; k++) begin
      applyStimulus(3'b011, 1'b0);
      checkOutput("limit_grant", 8'(Grant), ((k / MAX_HOLD) % 2 == 0) ? 8'h01 : 8'h02);
    end
    applyStimulus(3'b000, 1'b1);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(3'b001, 1'b0);
      checkOutput("solo_grant", 8'(Grant), 8'h01);
    end
`else
    for (int k = 0; k < 50; k++) begin
      applyStimulus(3'b011, 1'b0);
      checkOutput("nolimit_grant", 8'(Grant), 8'h01);
    end
`endif

    // Randomised traffic with occasional resets; requests tend to stay high.
    for (int k = 0; k < 400; k++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) r = r | 3'($urandom_range(0, 7));
      applyStimulus(r, ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
